// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch (I) and load/store (D) ports, one access in flight at a time.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  m_en,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_d_q;
    logic               win_d_q;
    logic               any_req;
    logic               grant_d;
    logic               last_wait;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // D wins alone, or on contention when I was granted last.
    always_comb begin
        any_req   = i_req || d_req;
        grant_d   = d_req && (!i_req || !last_d_q);
        last_wait = (cnt_q == CNT_W'(1));
        state_d   = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = WAIT;
            WAIT:    if (last_wait) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            last_d_q <= 1'b0;
            win_d_q  <= 1'b0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_wstrb  <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            i_rdata  <= '0;
            i_ack    <= 1'b0;
            d_rdata  <= '0;
            d_ack    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_d_q  <= grant_d;
                        last_d_q <= grant_d;
                        m_en     <= 1'b1;
                        if (grant_d) begin
                            m_we    <= d_we;
                            m_wstrb <= d_we ? d_wstrb : STRB_W'(0);
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_we    <= 1'b0;
                            m_wstrb <= '0;
                            m_addr  <= i_addr;
                        end
                    end
                end
                ACCESS: begin
                    m_en    <= 1'b0;
                    m_we    <= 1'b0;
                    m_wstrb <= '0;
                    cnt_q   <= CNT_W'(MEM_LATENCY);
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (last_wait) begin
                        if (win_d_q) begin
                            d_rdata <= m_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
